// File: rtl/dsp_pkg.sv
// Shared DSP definitions: frame sequencer state encoding and default widths
// used by the sequencer, the core and the host interface.
package dsp_pkg;

    localparam int unsigned PC_WIDTH_DEF  = 11;  // 2048 cycles per 48 kHz frame at 98.304 MHz
    localparam int unsigned CNT_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StRun,
        StDrain,
        StHalted
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   dsp_clk  : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   inc      : count one event (holds at all-ones)
//   clr      : clear; an inc in the same cycle wins and leaves the count at 1
//   count    : current count
module sat_counter
    import dsp_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 dsp_clk,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && clr) begin
            // The clear applies first, then the coincident event is counted.
            count_d = CNT_WIDTH'(1);
        end else if (inc) begin
            if (count_q != '1) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-sample frame sequencer for the DSP core. On each accepted frame_tick it
// walks the instruction address from 0 to prog_last, waits DRAIN_CYCLES for the
// core's writes to retire, then reports frame_done. Ticks arriving while a frame
// is busy are dropped and counted as overruns. The host can park the sequencer
// between frames with halt_req to get exclusive parameter-memory access.
//   dsp_clk, reset_n : clock and asynchronous active-low reset
//   enable           : allows new frames to start (only looked at between frames)
//   frame_tick       : one-cycle pulse per sample period
//   prog_last        : address of the last program instruction, latched per frame
//   halt_req         : host request to park between frames
//   clear_overrun    : clears overrun and overrun_count
//   pc, pc_valid     : instruction fetch address and fetch enable
//   frame_start      : one-cycle pulse on the first fetch of a frame
//   frame_done       : one-cycle pulse on the final drain cycle
//   halt_ack         : high while parked
//   overrun          : sticky, set by a tick that arrived while busy
//   overrun_count    : saturating count of such ticks
module frame_sequencer
    import dsp_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                 dsp_clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 frame_tick,
    input  logic [PC_WIDTH-1:0]  prog_last,
    input  logic                 halt_req,
    input  logic                 clear_overrun,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 pc_valid,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 halt_ack,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] overrun_count
);

    localparam int unsigned     DrainW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

    seq_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] last_q, last_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic                start_q, start_d;
    logic                overrun_q, overrun_d;
    logic                drain_final;
    logic                tick_overrun;

    assign drain_final = (state_q == StDrain) && (drain_q == DrainLast);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        last_d       = last_q;
        drain_d      = drain_q;
        start_d      = 1'b0;
        tick_overrun = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWaitTick;
                end
            end
            StWaitTick: begin
                // halt_req beats a coincident tick; the tick is simply lost.
                if (halt_req) begin
                    state_d = StHalted;
                end else if (!enable) begin
                    state_d = StIdle;
                end else if (frame_tick) begin
                    start_d = 1'b1;
                end
            end
            StRun: begin
                tick_overrun = frame_tick;
                if (pc_q == last_q) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    pc_d = pc_q + PC_WIDTH'(1);
                end
            end
            StDrain: begin
                if (drain_final) begin
                    // A tick on the last drain cycle is on time: start back-to-back.
                    if (halt_req) begin
                        state_d = StHalted;
                    end else if (frame_tick && enable) begin
                        start_d = 1'b1;
                    end else begin
                        state_d = StWaitTick;
                    end
                end else begin
                    tick_overrun = frame_tick;
                    drain_d      = drain_q + DrainW'(1);
                end
            end
            StHalted: begin
                if (!halt_req) begin
                    state_d = StWaitTick;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_d) begin
            state_d = StRun;
            pc_d    = '0;
            last_d  = prog_last;
        end
    end

    // Overrun wins over a coincident clear so the event is never lost.
    assign overrun_d = tick_overrun | (overrun_q & ~clear_overrun);

    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            last_q    <= '0;
            drain_q   <= '0;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            last_q    <= last_d;
            drain_q   <= drain_d;
            start_q   <= start_d;
            overrun_q <= overrun_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_overrun_cnt (
        .dsp_clk (dsp_clk),
        .reset_n (reset_n),
        .inc     (tick_overrun),
        .clr     (clear_overrun),
        .count   (overrun_count)
    );

    assign pc          = pc_q;
    assign pc_valid    = (state_q == StRun);
    assign frame_start = start_q;
    assign frame_done  = drain_final;
    assign halt_ack    = (state_q == StHalted);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

    localparam int PW = 11;
    localparam int CW = 8;
    localparam int D  = 4;

    // Reference model modes: where the block is in its frame life-cycle.
    localparam int MIdle  = 0;
    localparam int MWait  = 1;
    localparam int MFrame = 2;
    localparam int MHalt  = 3;

    logic          dsp_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_tick = 1'b0;
    logic          halt_req = 1'b0;
    logic          clear_overrun = 1'b0;
    logic [PW-1:0] prog_last = '0;
    logic [PW-1:0] pc;
    logic          pc_valid, frame_start, frame_done, halt_ack, overrun;
    logic [CW-1:0] overrun_count;
    logic [PW+CW+4:0] act_out;

    frame_sequencer #(
        .PC_WIDTH     (PW),
        .DRAIN_CYCLES (D),
        .CNT_WIDTH    (CW)
    ) dut (
        .dsp_clk       (dsp_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .frame_tick    (frame_tick),
        .prog_last     (prog_last),
        .halt_req      (halt_req),
        .clear_overrun (clear_overrun),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .halt_ack      (halt_ack),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    always #5 dsp_clk = ~dsp_clk;

    assign act_out = {pc, pc_valid, frame_start, frame_done, halt_ack, overrun, overrun_count};

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a frame is tracked by its age in cycles since frame_start. Fetches
    // occupy ages 0..last, the drain ages last+1..last+D, completion at last+D.
    typedef struct packed {
        int   mode;
        int   age;
        int   last;
        int   pc;
        logic ov;
        int   cnt;
    } mstate_t;

    mstate_t ms = '0;

    function automatic mstate_t model_next(mstate_t s, logic en, logic tick, logic halt,
                                           logic clr, int pl);
        mstate_t n = s;
        logic    late = 1'b0;
        logic    start = 1'b0;
        case (s.mode)
            MIdle: if (en) n.mode = MWait;
            MWait: begin
                if (halt) n.mode = MHalt;
                else if (!en) n.mode = MIdle;
                else if (tick) start = 1'b1;
            end
            MFrame: begin
                if (s.age == s.last + D) begin
                    if (halt) n.mode = MHalt;
                    else if (tick && en) start = 1'b1;
                    else n.mode = MWait;
                end else begin
                    late  = tick;
                    n.age = s.age + 1;
                end
            end
            default: if (!halt) n.mode = MWait;
        endcase
        if (start) begin
            n.mode = MFrame;
            n.age  = 0;
            n.last = pl;
        end
        if (n.mode == MFrame) n.pc = (n.age < n.last) ? n.age : n.last;
        if (clr) n.cnt = 0;
        if (late) n.cnt = (n.cnt >= (1 << CW) - 1) ? (1 << CW) - 1 : n.cnt + 1;
        n.ov = late ? 1'b1 : (clr ? 1'b0 : s.ov);
        return n;
    endfunction

    function automatic logic [PW+CW+4:0] exp_out(mstate_t s);
        logic in_frame;
        in_frame = (s.mode == MFrame);
        return {PW'(s.pc), in_frame && (s.age <= s.last), in_frame && (s.age == 0),
                in_frame && (s.age == s.last + D), s.mode == MHalt, s.ov, CW'(s.cnt)};
    endfunction

    always @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) ms <= '0;
        else ms <= model_next(ms, enable, frame_tick, halt_req, clear_overrun, int'(prog_last));
    end

    always @(negedge dsp_clk) begin
        if (reset_n && chk_on) check("model", 64'(act_out), 64'(exp_out(ms)));
    end

    // Vector: inputs {enable, tick, halt, clr}, prog_last; expected pc,
    // flags {pc_valid, frame_start, frame_done, halt_ack, overrun}, count.
    typedef struct packed {
        logic [3:0] in;
        int         pl;
        int         pc;
        logic [4:0] fl;
        int         cnt;
    } vec_t;

    function automatic vec_t mk(logic [3:0] in, int pl, int pc_e, logic [4:0] fl, int cnt);
        vec_t v;
        v.in = in; v.pl = pl; v.pc = pc_e; v.fl = fl; v.cnt = cnt;
        return v;
    endfunction

    task automatic cyc();
        @(posedge dsp_clk);
        #1;
    endtask

    initial begin
        vec_t vt [20];
        logic got;

        vt[0]  = mk(4'b0100, 2, 0, 5'b00000, 0);  // tick in IDLE ignored
        vt[1]  = mk(4'b1100, 2, 0, 5'b00000, 0);  // IDLE->WAIT, tick ignored
        vt[2]  = mk(4'b1100, 2, 0, 5'b11000, 0);  // frame starts
        vt[3]  = mk(4'b1000, 2, 1, 5'b10000, 0);
        vt[4]  = mk(4'b1100, 2, 2, 5'b10001, 1);  // tick during RUN
        vt[5]  = mk(4'b1000, 2, 2, 5'b00001, 1);  // drain, pc held
        vt[6]  = mk(4'b1100, 2, 2, 5'b00001, 2);  // tick in early drain
        vt[7]  = mk(4'b1000, 2, 2, 5'b00001, 2);
        vt[8]  = mk(4'b1000, 2, 2, 5'b00101, 2);  // final drain
        vt[9]  = mk(4'b1100, 2, 0, 5'b11001, 2);  // tick on final drain accepted
        vt[10] = mk(4'b1001, 2, 1, 5'b10000, 0);  // clear
        vt[11] = mk(4'b1010, 2, 2, 5'b10000, 0);  // halt mid-run
        vt[12] = mk(4'b0010, 2, 2, 5'b00000, 0);  // enable low does not abort
        vt[13] = mk(4'b0010, 2, 2, 5'b00000, 0);
        vt[14] = mk(4'b0010, 2, 2, 5'b00000, 0);
        vt[15] = mk(4'b0010, 2, 2, 5'b00100, 0);
        vt[16] = mk(4'b1010, 2, 2, 5'b00010, 0);  // halted
        vt[17] = mk(4'b1110, 2, 2, 5'b00010, 0);  // tick ignored while halted
        vt[18] = mk(4'b1000, 2, 2, 5'b00000, 0);  // release
        vt[19] = mk(4'b1100, 5, 0, 5'b11000, 0);  // next tick runs normally

        repeat (2) @(posedge dsp_clk);
        #1 check("reset_state", 64'(act_out), 64'd0);
        @(negedge dsp_clk);
        reset_n = 1'b1;
        chk_on  = 1'b1;

        for (int i = 0; i < 20; i++) begin
            {enable, frame_tick, halt_req, clear_overrun} = vt[i].in;
            prog_last = PW'(vt[i].pl);
            cyc();
            check($sformatf("vec%0d", i), 64'(act_out),
                  64'({PW'(vt[i].pc), vt[i].fl, CW'(vt[i].cnt)}));
        end
        {enable, frame_tick, halt_req, clear_overrun} = 4'b1000;
        repeat (12) cyc();

        // prog_last=7: eight fetches, frame_done four cycles after the last.
        prog_last = 11'd7;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        prog_last = 11'd0;
        for (int i = 0; i < 8; i++) begin
            check("a_fetch", 64'({pc, pc_valid, frame_start}),
                  64'({PW'(i), 1'b1, 1'(i == 0)}));
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            check("a_drain", 64'({pc, pc_valid, frame_done}), 64'({11'd7, 1'b0, 1'(k == 3)}));
            cyc();
        end

        // Full-length frame with late ticks from pc=3 on; count saturates.
        prog_last = 11'd2047;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        for (int i = 0; i < 20 && pc != 11'd3; i++) cyc();
        check("b_pc3", 64'(pc), 64'd3);
        frame_tick = 1'b1;
        cyc();
        check("b_ovr1", 64'({overrun, overrun_count}), 64'({1'b1, 8'd1}));
        repeat (299) cyc();
        frame_tick = 1'b0;
        check("b_sat", 64'({overrun, overrun_count}), 64'({1'b1, 8'd255}));
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (frame_done) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        check("b_done_seen", 64'(got), 64'd1);
        check("b_last_pc", 64'(pc), 64'd2047);
        cyc();

        // Clear coinciding with a late tick leaves count 1.
        prog_last = 11'd10;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        frame_tick = 1'b1;
        clear_overrun = 1'b1;
        cyc();
        frame_tick = 1'b0;
        clear_overrun = 1'b0;
        check("clr_coinc", 64'({overrun, overrun_count}), 64'({1'b1, 8'd1}));
        repeat (20) cyc();

        // Reset in the middle of a frame.
        prog_last = 11'd200;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        for (int i = 0; i < 150 && pc != 11'd100; i++) cyc();
        check("e_pc100", 64'(pc), 64'd100);
        #1 reset_n = 1'b0;
        enable = 1'b0;
        #1 check("e_rst_async", 64'(act_out), 64'd0);
        repeat (3) @(posedge dsp_clk);
        @(negedge dsp_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("e_quiet", 64'(act_out), 64'd0);
        end

        // Random traffic against the model.
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(19) == 0) enable = ~enable;
            if ($urandom_range(11) == 0) halt_req = ~halt_req;
            frame_tick    = ($urandom_range(4) == 0);
            clear_overrun = ($urandom_range(24) == 0);
            prog_last     = PW'($urandom_range(7));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
